// File: rtl/smoldvi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : smoldvi_pkg
// Brief   : Shared SmolDVI types and constants: link FSM state codes, the
//           idle/flush TMDS control symbol and a small sizing helper.
// Rev     : 1.0  initial release
// ============================================================================
package smoldvi_pkg;

  // Link controller state codes; the numeric values are visible on state_o.
  typedef enum logic [2:0] {
    ST_OFF       = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD      = 3'd2,
    ST_REL_OUT   = 3'd3,
    ST_REL_IN    = 3'd4,
    ST_FLUSH     = 3'd5,
    ST_RUN       = 3'd6
  } state_t;

  // TMDS control symbol for C1:C0 = 00, used while idling and flushing.
  localparam logic [9:0] c_CTRL_SYM = 10'b1101010100;

  // Cycles spent in REL_OUT so the fast domain can resynchronise its reset.
  localparam int c_REL_OUT_CYCLES = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/smoldvi_sync_bit.sv
`default_nettype none
// ============================================================================
// Module  : smoldvi_sync_bit
// Brief   : Two-flop synchroniser for a single asynchronous level, reset to 0.
// Rev     : 1.0  initial release
// ============================================================================
module smoldvi_sync_bit (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  // Capture the asynchronous level and let any metastability settle one stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/smoldvi_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : smoldvi_link_ctrl
// Brief   : DVI link bring-up controller. Waits for PLL lock, sequences the
//           gearbox output/input resets, flushes control symbols, then passes
//           encoder symbols through while flagging encoder underflow.
// Rev     : 1.0  initial release
// ============================================================================
module smoldvi_link_ctrl
  import smoldvi_pkg::*;
#(
  parameter int               N_LANES      = 3,
  parameter int               W_SYM        = 10,
  parameter int               HOLD_CYCLES  = 16,
  parameter int               FLUSH_CYCLES = 8,
  parameter logic [W_SYM-1:0] CTRL_SYM     = c_CTRL_SYM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     pll_locked,
  input  logic [N_LANES*W_SYM-1:0] enc_sym,
  input  logic                     enc_valid,
  output logic                     enc_ready,
  output logic [N_LANES*W_SYM-1:0] gb_sym,
  output logic                     gb_rst_n_in,
  output logic                     gb_rst_n_out,
  output logic                     link_up,
  output logic [2:0]               state_o,
  input  logic                     clear_err,
  output logic                     underflow
);

  localparam int c_CNT_MAX = max3(HOLD_CYCLES, FLUSH_CYCLES, c_REL_OUT_CYCLES);
  localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_HOLD_LAST  = c_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_REL_LAST   = c_CNT_W'(c_REL_OUT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_FLUSH_LAST = c_CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [N_LANES*W_SYM-1:0] c_CTRL_ALL = {N_LANES{CTRL_SYM}};

  logic               w_lock_s;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_gb_rst_n_in;
  logic               r_gb_rst_n_out;
  logic               r_link_up;
  logic               r_underflow;
  logic [N_LANES*W_SYM-1:0] r_gb_sym;

  smoldvi_sync_bit u_lock_sync (
    .clk (clk),
    .rst (rst),
    .i_d (pll_locked),
    .o_q (w_lock_s)
  );

  // Next-state and counter logic; losing enable or lock aborts to OFF.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_OFF: begin
        w_cnt_nxt = '0;
        if (enable) w_state_nxt = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        w_cnt_nxt = '0;
        if (w_lock_s) w_state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        if (r_cnt == c_HOLD_LAST) begin
          w_state_nxt = ST_REL_OUT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_REL_OUT: begin
        if (r_cnt == c_REL_LAST) begin
          w_state_nxt = ST_REL_IN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_REL_IN: begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = '0;
      end
      ST_FLUSH: begin
        if (r_cnt == c_FLUSH_LAST) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end
    endcase
    // WAIT_LOCK is where a missing lock is expected, so only enable aborts it.
    if (r_state != ST_OFF) begin
      if (!enable || (!w_lock_s && r_state != ST_WAIT_LOCK)) begin
        w_state_nxt = ST_OFF;
        w_cnt_nxt   = '0;
      end
    end
  end

  // State register with outputs registered from the next state so they line up with state_o.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_OFF;
      r_cnt          <= '0;
      r_gb_rst_n_in  <= 1'b0;
      r_gb_rst_n_out <= 1'b0;
      r_link_up      <= 1'b0;
      r_gb_sym       <= c_CTRL_ALL;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_gb_rst_n_out <= (w_state_nxt inside {ST_REL_OUT, ST_REL_IN, ST_FLUSH, ST_RUN});
      r_gb_rst_n_in  <= (w_state_nxt inside {ST_REL_IN, ST_FLUSH, ST_RUN});
      r_link_up      <= (w_state_nxt == ST_RUN);
      if (r_state == ST_RUN && w_state_nxt == ST_RUN && enc_valid)
        r_gb_sym <= enc_sym;
      else
        r_gb_sym <= c_CTRL_ALL;
    end
  end

  // Sticky underflow: a missing symbol in RUN wins over a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_underflow <= 1'b0;
    else if (r_state == ST_RUN && !enc_valid)
      r_underflow <= 1'b1;
    else if (clear_err)
      r_underflow <= 1'b0;
  end

  assign enc_ready    = (r_state == ST_RUN);
  assign gb_sym       = r_gb_sym;
  assign gb_rst_n_in  = r_gb_rst_n_in;
  assign gb_rst_n_out = r_gb_rst_n_out;
  assign link_up      = r_link_up;
  assign state_o      = r_state;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire
